input_vc_unit: RTL and testbench
================================

# input_vc_unit

Parametrised router input stage with per-port virtual-channel buffering. It pops single-flit packets from the upstream link FIFO and computes the output port (XY or YX dimension order). Each flit is stored with its route in one of NUM_VC small FIFOs. A round-robin head selector presents one flit per cycle, with its route and VC, to the switch allocator. It replaces the single-buffer input module on each of the five router ports (N/S/E/W/L).

## Interface
Parameters:
- MSB_SLOT, 5: log2 of flit width.
- DSIZE, 1<<MSB_SLOT: flit width in bits.
- RRSIZE, 1<<(MSB_SLOT-2): width of each coordinate field.
- NUM_VC, 2: number of virtual channels (power of two, ≥2); VCW = log2(NUM_VC).
- ADDRSIZE, 2: log2 of per-VC FIFO depth.
- DEPTH, 1<<ADDRSIZE: per-VC FIFO depth.
- PORT, 3'b000: port code of this input.
- ROUTER_X, 1: this router's X coordinate.
- ROUTER_Y, 1: this router's Y coordinate.
- ALGORITHM, 0: routing mode; 0 = XY, 1 = YX.

Ports:
- clk, in, 1: single clock; all state on rising edge.
- reset, in, 1: synchronous, active-high reset.
- data_in, in, DSIZE: upstream FIFO head flit.
- input_valid, in, 1: upstream FIFO non-empty.
- input_read, out, 1: pop strobe to upstream.
- data_out, out, DSIZE: selected head flit.
- out_valid, out, 1: data_out/out_port/out_vc valid.
- out_port, out, 3: route of selected flit.
- out_vc, out, VCW: VC of selected flit.
- read_en, in, 1: switch grant; pops the selected flit.
- vc_full, out, NUM_VC: per-VC full flags.
- drop_flit, out, 1: one-cycle pulse, illegal flit discarded.

## Operation
- Flit fields: dest_x = data_in[DSIZE-1 -: RRSIZE]; dest_y = data_in[DSIZE-1-RRSIZE -: RRSIZE]; target VC = data_in[VCW-1:0]. Coordinate comparisons are unsigned.
- Port codes: N=000, S=001, E=010, W=011, L=100, INVALID=111.
- XY routing: dest_x>ROUTER_X → E; dest_x<ROUTER_X → W; otherwise dest_y>ROUTER_Y → S; dest_y<ROUTER_Y → N; otherwise L.
- YX routing: Y is compared first, then X, with the same codes.
- Illegal route: if the computed port equals PORT and PORT≠L (U-turn), route = INVALID. The flit is popped (input_read=1) but not buffered, and drop_flit pulses high for the next cycle.
- Accept: input_read = input_valid & ~reset & (route INVALID | ~vc_full[target VC]). On the accept edge the flit and its 3-bit route are written to the target VC FIFO.
- No bypass of a full VC: the upstream head blocks (head-of-line blocking) until that VC frees. A flit for another VC behind it waits.
- Head select: combinational. Choose the first non-empty VC scanning rr_ptr, rr_ptr+1, … modulo NUM_VC. out_valid = any VC non-empty.
- Pop: on read_en & out_valid, the selected VC FIFO is popped and rr_ptr ← selected+1 (mod NUM_VC). read_en while out_valid=0 is ignored.
- Simultaneous write and pop on the same VC: both take effect and the count is unchanged. The full flag is evaluated before the pop, so a full VC cannot accept a write even when it is popped in the same cycle.
- Idle outputs: when out_valid=0, data_out=0, out_port=INVALID (111), out_vc=0.

## Timing
- Reset (on a rising edge with reset=1): all FIFO pointers and counts = 0; rr_ptr = 0; vc_full = 0; drop_flit = 0; out_valid = 0; data_out = 0; out_port = 111; out_vc = 0; input_read = 0 while reset is high.
- Reset asserted mid-operation flushes every buffered flit. The upstream flit presented that cycle is not popped.
- Latency: a flit accepted at edge k appears on data_out after edge k (1 cycle), provided its VC is selected.
- Throughput: one accept and one pop per cycle, sustained.
- vc_full[v] is high when count[v]==DEPTH. Pointers wrap modulo DEPTH. Counts are ADDRSIZE+1 bits wide.

## Structure
- Shared package noc_pkg holds:
  - port codes N/S/E/W/L/INVALID;
  - ALGORITHM encodings;
  - flit field-extraction helpers;
  - the route-compute function, which is reused by the output/arbiter blocks.
- Sub-module vc_fifo (DSIZE+3 bits wide, DEPTH deep, synchronous reset, full/empty/count outputs) is instantiated NUM_VC times via generate.
- Round-robin select and accept logic are in the top level.

## Test plan
Default setup: ROUTER_X=ROUTER_Y=1, PORT=000 (N), NUM_VC=2, ADDRSIZE=2.
- Reset, then data_in=0x01020001 with input_valid=1 for one cycle → input_read=1; next cycle out_valid=1, data_out=0x01020001, out_port=001 (S), out_vc=1.
- 0x00010000 then 0x01020001 buffered, read_en held high → order follows round robin from rr_ptr=0: VC0 (out_port=011, W) first, then VC1 (001); out_valid=0 afterwards.
- data_in=0x01000000 (dest (1,0), routes N = PORT) → input_read=1, drop_flit=1 next cycle, out_valid stays 0. Repeat with PORT=100 and dest (1,1) → accepted, out_port=100.
- Five flits to VC0 with read_en=0 → vc_full[0]=1 after the fourth; input_read=0 for the fifth. One read_en → fifth accepted on the next edge and vc_full[0] stays 1.
- ALGORITHM=1, data_in=0x02020000 → out_port=001 (S); with ALGORITHM=0 the same flit gives 010 (E).
- Three flits buffered, reset pulsed one cycle → out_valid=0, vc_full=0, out_port=111; the next accepted flit emerges alone one cycle after its accept.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: port codes, routing modes, flit field helpers
// and the dimension-order route computation used by router blocks.
package noc_pkg;

  typedef logic [2:0] port_t;

  localparam port_t PORT_N       = 3'b000;
  localparam port_t PORT_S       = 3'b001;
  localparam port_t PORT_E       = 3'b010;
  localparam port_t PORT_W       = 3'b011;
  localparam port_t PORT_L       = 3'b100;
  localparam port_t PORT_INVALID = 3'b111;

  localparam int ALG_XY = 0;
  localparam int ALG_YX = 1;

  // Helpers work on the widest supported flit/coordinate and are narrowed by callers.
  localparam int MAX_DSIZE   = 64;
  localparam int MAX_COORD_W = 16;

  typedef logic [MAX_DSIZE-1:0]   flit_max_t;
  typedef logic [MAX_COORD_W-1:0] coord_t;

  function automatic coord_t coord_mask(input int unsigned rrsize);
    logic [MAX_COORD_W:0] m;
    m = ({{MAX_COORD_W{1'b0}}, 1'b1} << rrsize) - {{MAX_COORD_W{1'b0}}, 1'b1};
    return coord_t'(m);
  endfunction

  // Destination X sits in the top RRSIZE bits of the flit.
  function automatic coord_t flit_dest_x(input flit_max_t flit, input int unsigned dsize,
                                         input int unsigned rrsize);
    flit_max_t sh;
    sh = flit >> (dsize - rrsize);
    return coord_t'(sh) & coord_mask(rrsize);
  endfunction

  // Destination Y sits directly below destination X.
  function automatic coord_t flit_dest_y(input flit_max_t flit, input int unsigned dsize,
                                         input int unsigned rrsize);
    flit_max_t sh;
    sh = flit >> (dsize - 2 * rrsize);
    return coord_t'(sh) & coord_mask(rrsize);
  endfunction

  // Dimension-order routing; unsigned coordinate compares, X first for XY, Y first for YX.
  function automatic port_t route_compute(input coord_t dx, input coord_t dy,
                                          input coord_t rx, input coord_t ry,
                                          input int alg);
    port_t p;
    if (alg == ALG_YX) begin
      if (dy > ry)      p = PORT_S;
      else if (dy < ry) p = PORT_N;
      else if (dx > rx) p = PORT_E;
      else if (dx < rx) p = PORT_W;
      else              p = PORT_L;
    end else begin
      if (dx > rx)      p = PORT_E;
      else if (dx < rx) p = PORT_W;
      else if (dy > ry) p = PORT_S;
      else if (dy < ry) p = PORT_N;
      else              p = PORT_L;
    end
    return p;
  endfunction

endpackage

// File: rtl/input_vc_unit_if.sv
// Signal bundle between a router input stage, its upstream link FIFO and
// the switch allocator.
//
// Handshakes: the upstream link offers data_in while input_valid is high and
// the flit is consumed on a rising edge where input_read is high (input_read
// is never high without input_valid). Towards the allocator, data_out/out_port
// /out_vc are meaningful only while out_valid is high, and the flit is consumed
// on a rising edge where read_en and out_valid are both high.
interface input_vc_unit_if #(
  parameter int DSIZE  = 32,
  parameter int NUM_VC = 2
);
  localparam int VCW = $clog2(NUM_VC);

  logic [DSIZE-1:0]  data_in;
  logic              input_valid;
  logic              input_read;
  logic [DSIZE-1:0]  data_out;
  logic              out_valid;
  logic [2:0]        out_port;
  logic [VCW-1:0]    out_vc;
  logic              read_en;
  logic [NUM_VC-1:0] vc_full;
  logic              drop_flit;

  modport master (
    output data_in, input_valid, read_en,
    input  input_read, data_out, out_valid, out_port, out_vc, vc_full, drop_flit
  );

  modport slave (
    input  data_in, input_valid, read_en,
    output input_read, data_out, out_valid, out_port, out_vc, vc_full, drop_flit
  );
endinterface

// File: rtl/vc_fifo.sv
// One virtual-channel buffer: small synchronous FIFO with a combinational
// head, full/empty flags and an occupancy count.
module vc_fifo #(
  parameter int W        = 35,
  parameter int ADDRSIZE = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [W-1:0]      wr_data,
  input  logic              rd_en,
  output logic [W-1:0]      rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDRSIZE:0] count
);
  localparam int DEPTH = 1 << ADDRSIZE;

  logic [W-1:0]        mem [DEPTH];
  logic [ADDRSIZE-1:0] wr_ptr;
  logic [ADDRSIZE-1:0] rd_ptr;
  logic                do_wr;
  logic                do_rd;

  assign full    = (count == (ADDRSIZE+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally; count is unchanged on simultaneous write and read.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + ADDRSIZE'(1);
      if (do_rd) rd_ptr <= rd_ptr + ADDRSIZE'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (ADDRSIZE+1)'(1);
        2'b01:   count <= count - (ADDRSIZE+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/input_vc_unit.sv
// Router input stage: pops flits from the upstream link, routes them, drops
// U-turns, buffers them per virtual channel and presents one head flit per
// cycle to the switch allocator under round-robin VC selection.
module input_vc_unit
  import noc_pkg::*;
#(
  parameter int    MSB_SLOT  = 5,
  parameter int    DSIZE     = 1 << MSB_SLOT,
  parameter int    RRSIZE    = 1 << (MSB_SLOT - 2),
  parameter int    NUM_VC    = 2,
  parameter int    ADDRSIZE  = 2,
  parameter int    DEPTH     = 1 << ADDRSIZE,
  parameter port_t PORT      = PORT_N,
  parameter int    ROUTER_X  = 1,
  parameter int    ROUTER_Y  = 1,
  parameter int    ALGORITHM = ALG_XY
) (
  input logic             clk,
  input logic             reset,
  input_vc_unit_if.slave  bus
);
  localparam int VCW = $clog2(NUM_VC);
  localparam int W   = DSIZE + 3;

  flit_max_t         flit_ext;
  coord_t            dest_x;
  coord_t            dest_y;
  port_t             route;
  logic              illegal;
  port_t             route_final;
  logic [VCW-1:0]    target_vc;
  logic [W-1:0]      wr_data;
  logic [NUM_VC-1:0] wr_en;
  logic [NUM_VC-1:0] rd_en;
  logic [NUM_VC-1:0] full_v;
  logic [NUM_VC-1:0] empty_v;
  logic [W-1:0]      head_q [NUM_VC];
  logic [VCW-1:0]    rr_ptr;
  logic [VCW-1:0]    sel_vc;
  logic              found;
  logic              drop_q;
  logic              pop;

  assign flit_ext    = flit_max_t'(bus.data_in);
  assign dest_x      = flit_dest_x(flit_ext, DSIZE, RRSIZE);
  assign dest_y      = flit_dest_y(flit_ext, DSIZE, RRSIZE);
  assign route       = route_compute(dest_x, dest_y, coord_t'(ROUTER_X), coord_t'(ROUTER_Y),
                                     ALGORITHM);
  // A flit routed back out of the port it came in on is a U-turn, except at the local port.
  assign illegal     = (route == PORT) && (PORT != PORT_L);
  assign route_final = illegal ? PORT_INVALID : route;
  assign target_vc   = bus.data_in[VCW-1:0];
  assign wr_data     = {bus.data_in, route_final};

  // Head-of-line blocking: a full target VC stalls the link; dropped flits never wait.
  assign bus.input_read = bus.input_valid & ~reset & (illegal | ~full_v[target_vc]);
  assign bus.vc_full    = full_v;
  assign pop            = bus.read_en & found;

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    logic [ADDRSIZE:0] cnt;
    logic              unused_cnt;

    assign wr_en[v]   = bus.input_read & ~illegal & (target_vc == VCW'(v));
    assign rd_en[v]   = pop & (sel_vc == VCW'(v));
    assign unused_cnt = ^cnt;

    vc_fifo #(.W(W), .ADDRSIZE(ADDRSIZE)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en[v]),
      .wr_data (wr_data),
      .rd_en   (rd_en[v]),
      .rd_data (head_q[v]),
      .full    (full_v[v]),
      .empty   (empty_v[v]),
      .count   (cnt)
    );
  end

  // Round-robin head select: first non-empty VC starting at rr_ptr.
  always_comb begin
    logic [VCW-1:0] idx;
    idx    = '0;
    sel_vc = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_VC; i++) begin
      idx = rr_ptr + VCW'(i);
      if (!found && !empty_v[idx]) begin
        found  = 1'b1;
        sel_vc = idx;
      end
    end
  end

  // Selected head drives the allocator; idle outputs are forced to known values.
  always_comb begin
    bus.out_valid = found;
    bus.data_out  = '0;
    bus.out_port  = PORT_INVALID;
    bus.out_vc    = '0;
    if (found) begin
      bus.data_out = head_q[sel_vc][W-1:3];
      bus.out_port = head_q[sel_vc][2:0];
      bus.out_vc   = sel_vc;
    end
  end

  // Pointer moves past the VC just served so the others get the next turn.
  always_ff @(posedge clk) begin
    if (reset)    rr_ptr <= '0;
    else if (pop) rr_ptr <= sel_vc + VCW'(1);
  end

  // Drop notification follows the edge on which the illegal flit was popped.
  always_ff @(posedge clk) begin
    if (reset) drop_q <= 1'b0;
    else       drop_q <= bus.input_read & illegal;
  end

  assign bus.drop_flit = drop_q;
endmodule

// File: tb/tb_input_vc_unit.sv
// Bench for input_vc_unit: a table of directed cycles on a default XY/north
// instance, plus hand sequences for reset flush and a local-port/YX instance.
module tb_input_vc_unit;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [31:0] exp_q [$];

  input_vc_unit_if #(.DSIZE(32), .NUM_VC(2)) bus_a ();
  input_vc_unit_if #(.DSIZE(32), .NUM_VC(2)) bus_b ();

  input_vc_unit #(.PORT(3'b000), .ALGORITHM(0)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  input_vc_unit #(.PORT(3'b100), .ALGORITHM(1)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] din;
    logic        iv;
    logic        ren;
    logic        exp_rd;
    logic        exp_ov;
    logic [31:0] exp_dout;
    logic [2:0]  exp_port;
    logic        exp_vc;
    logic [1:0]  exp_full;
    logic        exp_drop;
  } vec_t;

  vec_t tbl [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_a(input logic [31:0] din, input logic iv, input logic ren);
    bus_a.data_in     = din;
    bus_a.input_valid = iv;
    bus_a.read_en     = ren;
  endtask

  task automatic drive_b(input logic [31:0] din, input logic iv, input logic ren);
    bus_b.data_in     = din;
    bus_b.input_valid = iv;
    bus_b.read_en     = ren;
  endtask

  // One cycle: accept strobe checked before the edge, state outputs after it.
  task automatic apply_a(input vec_t v, input int idx);
    drive_a(v.din, v.iv, v.ren);
    #1;
    check($sformatf("v%0d input_read", idx), 32'(bus_a.input_read), 32'(v.exp_rd));
    @(posedge clk);
    #1;
    check($sformatf("v%0d out_valid", idx), 32'(bus_a.out_valid), 32'(v.exp_ov));
    check($sformatf("v%0d data_out", idx), bus_a.data_out, v.exp_dout);
    check($sformatf("v%0d out_port", idx), 32'(bus_a.out_port), 32'(v.exp_port));
    check($sformatf("v%0d out_vc", idx), 32'(bus_a.out_vc), 32'(v.exp_vc));
    check($sformatf("v%0d vc_full", idx), 32'(bus_a.vc_full), 32'(v.exp_full));
    check($sformatf("v%0d drop_flit", idx), 32'(bus_a.drop_flit), 32'(v.exp_drop));
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //             din           iv    ren   rd    ov    dout          port    vc    full   drop
    tbl[0]  = '{32'h01020001, 1'b1, 1'b0, 1'b1, 1'b1, 32'h01020001, 3'b001, 1'b1, 2'b00, 1'b0};
    tbl[1]  = '{32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00000000, 3'b111, 1'b0, 2'b00, 1'b0};
    tbl[2]  = '{32'h00010000, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00010000, 3'b011, 1'b0, 2'b00, 1'b0};
    tbl[3]  = '{32'h01020001, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00010000, 3'b011, 1'b0, 2'b00, 1'b0};
    tbl[4]  = '{32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1, 32'h01020001, 3'b001, 1'b1, 2'b00, 1'b0};
    tbl[5]  = '{32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00000000, 3'b111, 1'b0, 2'b00, 1'b0};
    tbl[6]  = '{32'h01000000, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00000000, 3'b111, 1'b0, 2'b00, 1'b1};
    tbl[7]  = '{32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00000000, 3'b111, 1'b0, 2'b00, 1'b0};
    tbl[8]  = '{32'h00010010, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00010010, 3'b011, 1'b0, 2'b00, 1'b0};
    tbl[9]  = '{32'h00010020, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00010010, 3'b011, 1'b0, 2'b00, 1'b0};
    tbl[10] = '{32'h00010030, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00010010, 3'b011, 1'b0, 2'b00, 1'b0};
    tbl[11] = '{32'h00010040, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00010010, 3'b011, 1'b0, 2'b01, 1'b0};
    tbl[12] = '{32'h00010050, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00010010, 3'b011, 1'b0, 2'b01, 1'b0};
    tbl[13] = '{32'h00010050, 1'b1, 1'b1, 1'b0, 1'b1, 32'h00010020, 3'b011, 1'b0, 2'b00, 1'b0};
    tbl[14] = '{32'h00010050, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00010020, 3'b011, 1'b0, 2'b01, 1'b0};
    tbl[15] = '{32'h01020001, 1'b1, 1'b1, 1'b1, 1'b1, 32'h01020001, 3'b001, 1'b1, 2'b00, 1'b0};
    tbl[16] = '{32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h01020001, 3'b001, 1'b1, 2'b00, 1'b0};

    // Reset with a flit offered: it must not be popped.
    reset = 1'b1;
    drive_a(32'h01020001, 1'b1, 1'b0);
    drive_b(32'h0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset input_read", 32'(bus_a.input_read), 32'd0);
    check("reset out_valid", 32'(bus_a.out_valid), 32'd0);
    check("reset data_out", bus_a.data_out, 32'd0);
    check("reset out_port", 32'(bus_a.out_port), 32'd7);
    check("reset out_vc", 32'(bus_a.out_vc), 32'd0);
    check("reset vc_full", 32'(bus_a.vc_full), 32'd0);
    check("reset drop_flit", 32'(bus_a.drop_flit), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) apply_a(tbl[i], i);

    // Reset mid-operation flushes four buffered flits; offered flit is not popped.
    reset = 1'b1;
    drive_a(32'h01020001, 1'b1, 1'b0);
    #1;
    check("flush input_read", 32'(bus_a.input_read), 32'd0);
    @(posedge clk);
    #1;
    check("flush out_valid", 32'(bus_a.out_valid), 32'd0);
    check("flush vc_full", 32'(bus_a.vc_full), 32'd0);
    check("flush out_port", 32'(bus_a.out_port), 32'd7);
    reset = 1'b0;
    drive_a(32'h00010000, 1'b1, 1'b0);
    #1;
    check("post-flush input_read", 32'(bus_a.input_read), 32'd1);
    @(posedge clk);
    #1;
    check("post-flush out_valid", 32'(bus_a.out_valid), 32'd1);
    check("post-flush data_out", bus_a.data_out, 32'h00010000);
    check("post-flush out_vc", 32'(bus_a.out_vc), 32'd0);
    drive_a(32'h0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check("post-flush alone", 32'(bus_a.out_valid), 32'd0);

    // XY routing of dest (2,2) from (1,1) goes east.
    drive_a(32'h02020000, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check("xy out_port", 32'(bus_a.out_port), 32'd2);
    drive_a(32'h0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check("xy drained", 32'(bus_a.out_valid), 32'd0);
    drive_a(32'h0, 1'b0, 1'b0);

    // Local-port YX instance: local dest is legal, YX sends (2,2) south.
    drive_b(32'h01010000, 1'b1, 1'b0);
    exp_q.push_back(32'h01010000);
    #1;
    check("b local input_read", 32'(bus_b.input_read), 32'd1);
    @(posedge clk);
    #1;
    check("b local out_port", 32'(bus_b.out_port), 32'd4);
    check("b local out_valid", 32'(bus_b.out_valid), 32'd1);
    check("b local drop_flit", 32'(bus_b.drop_flit), 32'd0);
    drive_b(32'h02020000, 1'b1, 1'b1);
    exp_q.push_back(32'h02020000);
    #1;
    if (exp_q.size() == 0) check("b queue empty", 32'd1, 32'd0);
    else                   check("b pop data_out", bus_b.data_out, exp_q.pop_front());
    @(posedge clk);
    #1;
    check("b yx out_port", 32'(bus_b.out_port), 32'd1);
    drive_b(32'h0, 1'b0, 1'b1);
    #1;
    if (exp_q.size() == 0) check("b queue empty", 32'd1, 32'd0);
    else                   check("b pop data_out", bus_b.data_out, exp_q.pop_front());
    @(posedge clk);
    #1;
    check("b drained", 32'(bus_b.out_valid), 32'd0);
    drive_b(32'h0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
